// File: rtl/imem_load_controller.sv
// Loads the byte-wide instruction memory from a 32-bit word stream, writing each
// word as four little-endian bytes while holding the CPU in stall.
module imem_load_controller #(
    parameter int                ADDR_W    = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [ADDR_W-2:0] load_len,
    input  logic              s_valid,
    input  logic [31:0]       s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_stall,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-2:0] words_left
);

    localparam int LEN_W = ADDR_W - 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_WORD,
        WRITE,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] ptr;
    logic [1:0]        byte_idx;
    logic [31:0]       word;
    logic [LEN_W-1:0]  words_cnt;
    logic              real_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (load_start) begin
                    state_next = (load_len != '0) ? WAIT_WORD : DONE;
                end
            end
            WAIT_WORD: begin
                if (s_valid) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (byte_idx == 2'd3) begin
                    state_next = (words_cnt == LEN_W'(1)) ? DONE : WAIT_WORD;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // real_load separates a genuine load's DONE (stall held) from a zero-length one.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= BASE_ADDR;
            byte_idx  <= 2'd0;
            word      <= 32'd0;
            words_cnt <= '0;
            real_load <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_start) begin
                        ptr       <= BASE_ADDR;
                        words_cnt <= load_len;
                        real_load <= (load_len != '0);
                    end
                end
                WAIT_WORD: begin
                    if (s_valid) begin
                        word     <= s_data;
                        byte_idx <= 2'd0;
                    end
                end
                WRITE: begin
                    ptr      <= ptr + ADDR_W'(1);
                    byte_idx <= byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        words_cnt <= words_cnt - LEN_W'(1);
                    end
                end
                DONE: begin
                    real_load <= 1'b0;
                end
                default: begin
                    real_load <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        s_ready    = (state == WAIT_WORD);
        mem_we     = (state == WRITE);
        busy       = (state == WAIT_WORD) || (state == WRITE);
        done       = (state == DONE);
        cpu_stall  = busy || ((state == DONE) && real_load);
        mem_waddr  = (state == WRITE) ? ptr : '0;
        mem_wdata  = (state == WRITE) ? word[{byte_idx, 3'b000} +: 8] : 8'd0;
        words_left = words_cnt;
    end

endmodule

// File: tb/tb_imem_load_controller.sv
// Directed bench for imem_load_controller: one default-base instance and one
// instance based near the top of memory to exercise address wrap.
module tb_imem_load_controller;

    logic        clk;
    logic        rst;
    logic        load_start;
    logic [10:0] load_len;
    logic        s_valid;
    logic [31:0] s_data;

    logic        s_ready_a, mem_we_a, cpu_stall_a, busy_a, done_a;
    logic [11:0] mem_waddr_a;
    logic [7:0]  mem_wdata_a;
    logic [10:0] words_left_a;

    logic        s_ready_b, mem_we_b, cpu_stall_b, busy_b, done_b;
    logic [11:0] mem_waddr_b;
    logic [7:0]  mem_wdata_b;
    logic [10:0] words_left_b;

    int checks;
    int passes;
    int wr_count_a;

    imem_load_controller #(.ADDR_W(12), .BASE_ADDR(12'd0)) dut_a (
        .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_a),
        .mem_we(mem_we_a), .mem_waddr(mem_waddr_a), .mem_wdata(mem_wdata_a),
        .cpu_stall(cpu_stall_a), .busy(busy_a), .done(done_a),
        .words_left(words_left_a)
    );

    imem_load_controller #(.ADDR_W(12), .BASE_ADDR(12'd4092)) dut_b (
        .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_b),
        .mem_we(mem_we_b), .mem_waddr(mem_waddr_b), .mem_wdata(mem_wdata_b),
        .cpu_stall(cpu_stall_b), .busy(busy_b), .done(done_b),
        .words_left(words_left_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts bytes the memory would capture on each rising edge of dut_a.
    always @(negedge clk) begin
        if (mem_we_a === 1'b1) wr_count_a = wr_count_a + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        checks = checks + 1;
        if (mem_we_a !== 1'b0) $display("[TB] FAIL por_mem_we: got %0b want 0", mem_we_a); else passes = passes + 1;
        checks = checks + 1;
        if (cpu_stall_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0 || s_ready_a !== 1'b0)
            $display("[TB] FAIL por_ctrl: got stall=%0b busy=%0b done=%0b rdy=%0b want all 0", cpu_stall_a, busy_a, done_a, s_ready_a);
        else passes = passes + 1;
        checks = checks + 1;
        if (words_left_a !== 11'd0 || mem_waddr_a !== 12'd0 || mem_wdata_a !== 8'd0)
            $display("[TB] FAIL por_data: got left=%0d addr=%0d data=%0h want 0", words_left_a, mem_waddr_a, mem_wdata_a);
        else passes = passes + 1;

        // reset again in the middle of a WRITE
        load_start = 1'b1; load_len = 11'd1;
        tick;
        load_start = 1'b0;
        s_valid = 1'b1; s_data = 32'hCAFEF00D;
        tick;
        s_valid = 1'b0;
        checks = checks + 1;
        if (mem_we_a !== 1'b1) $display("[TB] FAIL rst_pre_write: got mem_we=%0b want 1", mem_we_a); else passes = passes + 1;
        tick;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        checks = checks + 1;
        if (mem_we_a !== 1'b0 || s_ready_a !== 1'b0 || cpu_stall_a !== 1'b0 || busy_a !== 1'b0 || words_left_a !== 11'd0)
            $display("[TB] FAIL rst_mid_write: got we=%0b rdy=%0b stall=%0b busy=%0b left=%0d want all 0",
                     mem_we_a, s_ready_a, cpu_stall_a, busy_a, words_left_a);
        else passes = passes + 1;
        tick;
        checks = checks + 1;
        if (mem_we_a !== 1'b0 || busy_a !== 1'b0) $display("[TB] FAIL rst_release_idle: got we=%0b busy=%0b want 0 0", mem_we_a, busy_a); else passes = passes + 1;
    endtask

    task automatic test_single_word;
        logic [7:0] exp_bytes [4];
        exp_bytes[0] = 8'h28; exp_bytes[1] = 8'h00; exp_bytes[2] = 8'h01; exp_bytes[3] = 8'h20;
        load_start = 1'b1; load_len = 11'd1;
        tick;
        load_start = 1'b0;
        checks = checks + 1;
        if (s_ready_a !== 1'b1 || busy_a !== 1'b1 || cpu_stall_a !== 1'b1 || words_left_a !== 11'd1)
            $display("[TB] FAIL single_wait: got rdy=%0b busy=%0b stall=%0b left=%0d want 1 1 1 1", s_ready_a, busy_a, cpu_stall_a, words_left_a);
        else passes = passes + 1;
        s_valid = 1'b1; s_data = 32'h20010028;
        tick;
        s_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks = checks + 1;
            if (mem_we_a !== 1'b1 || mem_waddr_a !== 12'(i) || mem_wdata_a !== exp_bytes[i] || s_ready_a !== 1'b0)
                $display("[TB] FAIL single_byte%0d: got we=%0b addr=%0d data=%02h rdy=%0b want 1 %0d %02h 0",
                         i, mem_we_a, mem_waddr_a, mem_wdata_a, s_ready_a, i, exp_bytes[i]);
            else passes = passes + 1;
            tick;
        end
        checks = checks + 1;
        if (done_a !== 1'b1 || cpu_stall_a !== 1'b1 || mem_we_a !== 1'b0 || words_left_a !== 11'd0 || busy_a !== 1'b0)
            $display("[TB] FAIL single_done: got done=%0b stall=%0b we=%0b left=%0d busy=%0b want 1 1 0 0 0",
                     done_a, cpu_stall_a, mem_we_a, words_left_a, busy_a);
        else passes = passes + 1;
        // load_start during DONE must be ignored
        load_start = 1'b1; load_len = 11'd5;
        tick;
        load_start = 1'b0;
        checks = checks + 1;
        if (done_a !== 1'b0 || cpu_stall_a !== 1'b0 || busy_a !== 1'b0)
            $display("[TB] FAIL single_after: got done=%0b stall=%0b busy=%0b want 0 0 0", done_a, cpu_stall_a, busy_a);
        else passes = passes + 1;
        tick;
        checks = checks + 1;
        if (busy_a !== 1'b0 || s_ready_a !== 1'b0) $display("[TB] FAIL start_in_done_ignored: got busy=%0b rdy=%0b want 0 0", busy_a, s_ready_a); else passes = passes + 1;
    endtask

    task automatic test_gaps;
        logic [31:0] words [3];
        int          start_count;
        words[0] = 32'h03020100; words[1] = 32'h07060504; words[2] = 32'h0B0A0908;
        start_count = wr_count_a;
        load_start = 1'b1; load_len = 11'd3;
        tick;
        load_start = 1'b0;
        for (int w = 0; w < 3; w++) begin
            checks = checks + 1;
            if (words_left_a !== 11'(3 - w)) $display("[TB] FAIL gap_left%0d: got %0d want %0d", w, words_left_a, 3 - w); else passes = passes + 1;
            for (int g = 0; g < 2; g++) begin
                tick;
                checks = checks + 1;
                if (mem_we_a !== 1'b0 || s_ready_a !== 1'b1)
                    $display("[TB] FAIL gap_idle%0d_%0d: got we=%0b rdy=%0b want 0 1", w, g, mem_we_a, s_ready_a);
                else passes = passes + 1;
            end
            s_valid = 1'b1; s_data = words[w];
            tick;
            // keep valid high during the first byte; it must not be re-accepted
            s_data = 32'hFFFFFFFF;
            for (int i = 0; i < 4; i++) begin
                checks = checks + 1;
                if (mem_we_a !== 1'b1 || mem_waddr_a !== 12'(4 * w + i) || mem_wdata_a !== 8'(4 * w + i))
                    $display("[TB] FAIL gap_w%0d_b%0d: got we=%0b addr=%0d data=%02h want 1 %0d %02h",
                             w, i, mem_we_a, mem_waddr_a, mem_wdata_a, 4 * w + i, 4 * w + i);
                else passes = passes + 1;
                tick;
                s_valid = 1'b0;
            end
        end
        checks = checks + 1;
        if (done_a !== 1'b1 || words_left_a !== 11'd0) $display("[TB] FAIL gap_done: got done=%0b left=%0d want 1 0", done_a, words_left_a); else passes = passes + 1;
        tick;
        checks = checks + 1;
        if (wr_count_a - start_count !== 12) $display("[TB] FAIL gap_write_count: got %0d want 12", wr_count_a - start_count); else passes = passes + 1;
    endtask

    task automatic test_zero_len;
        int start_count;
        start_count = wr_count_a;
        // s_valid in IDLE is ignored
        s_valid = 1'b1; s_data = 32'h12345678;
        tick;
        checks = checks + 1;
        if (s_ready_a !== 1'b0 || mem_we_a !== 1'b0 || busy_a !== 1'b0)
            $display("[TB] FAIL idle_valid_ignored: got rdy=%0b we=%0b busy=%0b want 0 0 0", s_ready_a, mem_we_a, busy_a);
        else passes = passes + 1;
        s_valid = 1'b0;
        load_start = 1'b1; load_len = 11'd0;
        tick;
        load_start = 1'b0;
        checks = checks + 1;
        if (done_a !== 1'b1 || cpu_stall_a !== 1'b0 || mem_we_a !== 1'b0 || busy_a !== 1'b0)
            $display("[TB] FAIL zero_done: got done=%0b stall=%0b we=%0b busy=%0b want 1 0 0 0", done_a, cpu_stall_a, mem_we_a, busy_a);
        else passes = passes + 1;
        tick;
        checks = checks + 1;
        if (done_a !== 1'b0 || cpu_stall_a !== 1'b0) $display("[TB] FAIL zero_after: got done=%0b stall=%0b want 0 0", done_a, cpu_stall_a); else passes = passes + 1;
        checks = checks + 1;
        if (wr_count_a !== start_count) $display("[TB] FAIL zero_writes: got %0d want 0", wr_count_a - start_count); else passes = passes + 1;
    endtask

    task automatic test_wrap;
        logic [11:0] exp_addr [8];
        logic [7:0]  exp_data [8];
        logic [31:0] words [2];
        words[0] = 32'hAABBCCDD; words[1] = 32'h11223344;
        exp_addr[0] = 12'd4092; exp_addr[1] = 12'd4093; exp_addr[2] = 12'd4094; exp_addr[3] = 12'd4095;
        exp_addr[4] = 12'd0;    exp_addr[5] = 12'd1;    exp_addr[6] = 12'd2;    exp_addr[7] = 12'd3;
        exp_data[0] = 8'hDD; exp_data[1] = 8'hCC; exp_data[2] = 8'hBB; exp_data[3] = 8'hAA;
        exp_data[4] = 8'h44; exp_data[5] = 8'h33; exp_data[6] = 8'h22; exp_data[7] = 8'h11;
        load_start = 1'b1; load_len = 11'd2;
        tick;
        load_start = 1'b0;
        checks = checks + 1;
        if (s_ready_b !== 1'b1 || words_left_b !== 11'd2) $display("[TB] FAIL wrap_wait: got rdy=%0b left=%0d want 1 2", s_ready_b, words_left_b); else passes = passes + 1;
        for (int w = 0; w < 2; w++) begin
            s_valid = 1'b1; s_data = words[w];
            tick;
            s_valid = 1'b0;
            for (int i = 0; i < 4; i++) begin
                checks = checks + 1;
                if (mem_we_b !== 1'b1 || mem_waddr_b !== exp_addr[4 * w + i] || mem_wdata_b !== exp_data[4 * w + i])
                    $display("[TB] FAIL wrap_byte%0d: got we=%0b addr=%0d data=%02h want 1 %0d %02h",
                             4 * w + i, mem_we_b, mem_waddr_b, mem_wdata_b, exp_addr[4 * w + i], exp_data[4 * w + i]);
                else passes = passes + 1;
                tick;
            end
        end
        checks = checks + 1;
        if (done_b !== 1'b1 || cpu_stall_b !== 1'b1 || busy_b !== 1'b0)
            $display("[TB] FAIL wrap_done: got done=%0b stall=%0b busy=%0b want 1 1 0", done_b, cpu_stall_b, busy_b);
        else passes = passes + 1;
        tick;
    endtask

    task automatic test_abort;
        logic [7:0] exp_bytes [4];
        exp_bytes[0] = 8'hEF; exp_bytes[1] = 8'hBE; exp_bytes[2] = 8'hAD; exp_bytes[3] = 8'hDE;
        load_start = 1'b1; load_len = 11'd2;
        tick;
        load_start = 1'b0;
        s_valid = 1'b1; s_data = 32'h44332211;
        tick;
        s_valid = 1'b0;
        tick;
        tick;
        tick;
        checks = checks + 1;
        if (mem_we_a !== 1'b1 || mem_waddr_a !== 12'd3) $display("[TB] FAIL abort_pre: got we=%0b addr=%0d want 1 3", mem_we_a, mem_waddr_a); else passes = passes + 1;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks = checks + 1;
        if (mem_we_a !== 1'b0 || cpu_stall_a !== 1'b0 || busy_a !== 1'b0 || words_left_a !== 11'd0)
            $display("[TB] FAIL abort_reset: got we=%0b stall=%0b busy=%0b left=%0d want 0 0 0 0", mem_we_a, cpu_stall_a, busy_a, words_left_a);
        else passes = passes + 1;
        load_start = 1'b1; load_len = 11'd1;
        tick;
        load_start = 1'b0;
        s_valid = 1'b1; s_data = 32'hDEADBEEF;
        tick;
        s_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks = checks + 1;
            if (mem_we_a !== 1'b1 || mem_waddr_a !== 12'(i) || mem_wdata_a !== exp_bytes[i])
                $display("[TB] FAIL abort_reload%0d: got we=%0b addr=%0d data=%02h want 1 %0d %02h",
                         i, mem_we_a, mem_waddr_a, mem_wdata_a, i, exp_bytes[i]);
            else passes = passes + 1;
            tick;
        end
        checks = checks + 1;
        if (done_a !== 1'b1) $display("[TB] FAIL abort_done: got %0b want 1", done_a); else passes = passes + 1;
        tick;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        wr_count_a = 0;
        rst = 1'b1;
        load_start = 1'b0;
        load_len = 11'd0;
        s_valid = 1'b0;
        s_data = 32'd0;
        test_reset;
        test_single_word;
        test_gaps;
        test_zero_len;
        test_wrap;
        test_abort;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
